twiddle_cmult_2_1: RTL and testbench

//  Stage-2 twiddle multiplier; sits directly downstream of the stage-2 coefficient ROM.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/cmult_pipe.sv | 60 ++++++
 rtl/twiddle_cmult_2_1.sv | 78 +++++++
 tb/tb_twiddle_cmult_2_1.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, sample/coefficient types and helpers for the stage-2 twiddle multiplier
package fft_pkg;
    localparam int DATA_W     = 16;
    localparam int COEFF_W    = 11;
    localparam int COEFF_FRAC = 9;
    localparam int FRAME_N    = 32;
    localparam int CNT_W      = $clog2(FRAME_N);
    localparam int PROD_W     = DATA_W + COEFF_W;
    localparam int SUM_W      = PROD_W + 1;
    localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(2**(DATA_W-1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-(2**(DATA_W-1)));
    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;
    typedef struct packed {
        logic signed [COEFF_W-1:0] re;
        logic signed [COEFF_W-1:0] im;
    } coeff_t;
    typedef enum logic [1:0] {IDLE, RUN, GAP} tw_state_t;
    function automatic logic [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] x);
        return x > SAT_HI ? DATA_W'(SAT_HI) : x < SAT_LO ? DATA_W'(SAT_LO) : x[DATA_W-1:0];
    endfunction
endpackage

// File: rtl/cmult_pipe.sv
// cmult_pipe: 4-stage complex multiplier (S0 register, S1 products, S2 sums, S3 shift+saturate)
//   in_valid/in_sof/in_eof : beat sideband, travels with the data
//   din, coeff             : sample and twiddle registered together in S0
//   out_valid/sof/eof,dout : result three edges after the S0 edge
//   TWIDDLE_ROUND_EN       : adds half an LSB before the shift (round half up), else truncates
module cmult_pipe
    import fft_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    input  logic   in_sof,
    input  logic   in_eof,
    input  cplx_t  din,
    input  coeff_t coeff,
    output logic   out_valid,
    output logic   out_sof,
    output logic   out_eof,
    output cplx_t  dout
);
`ifdef TWIDDLE_ROUND_EN
    localparam logic signed [SUM_W-1:0] RND = SUM_W'(2**(COEFF_FRAC-1));
`else
    localparam logic signed [SUM_W-1:0] RND = '0;
`endif
    logic [2:0] v, s, e;
    cplx_t d0;
    coeff_t c0;
    logic signed [PROD_W-1:0] rr, ii, ri, ir;
    logic signed [SUM_W-1:0] re2, im2;
    always_ff @(posedge clk) begin
        d0  <= din;
        c0  <= coeff;
        rr  <= PROD_W'($signed(d0.re)) * PROD_W'($signed(c0.re));
        ii  <= PROD_W'($signed(d0.im)) * PROD_W'($signed(c0.im));
        ri  <= PROD_W'($signed(d0.re)) * PROD_W'($signed(c0.im));
        ir  <= PROD_W'($signed(d0.im)) * PROD_W'($signed(c0.re));
        re2 <= SUM_W'(rr) - SUM_W'(ii) + RND;
        im2 <= SUM_W'(ri) + SUM_W'(ir) + RND;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v         <= '0;
            s         <= '0;
            e         <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            dout      <= '0;
        end else begin
            v         <= {v[1:0], in_valid};
            s         <= {s[1:0], in_sof};
            e         <= {e[1:0], in_eof};
            out_valid <= v[2];
            out_sof   <= s[2];
            out_eof   <= e[2];
            if (v[2]) dout <= {sat(re2 >>> COEFF_FRAC), sat(im2 >>> COEFF_FRAC)};
        end
    end
endmodule

// File: rtl/twiddle_cmult_2_1.sv
// twiddle_cmult_2_1: stage-2 twiddle multiplier, frames of FRAME_N beats paired with the coefficient ROM
//   clk, rst (sync, active-high)
//   in_valid/in_sof/in_ready/din : input beats, accepted on in_valid & in_ready
//   coeff_in/coeff_rst           : ROM word and ROM reset; coeff_rst holds the ROM index at 0
//   out_valid/out_sof/out_eof/dout : products, three edges after acceptance
//   frame_err                    : one-cycle pulse when a frame is aborted by a missing beat
//   TWIDDLE_ROUND_EN             : round half up instead of truncating the product
module twiddle_cmult_2_1
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic                 in_ready,
    input  logic [2*DATA_W-1:0]  din,
    input  logic [2*COEFF_W-1:0] coeff_in,
    output logic                 coeff_rst,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic [2*DATA_W-1:0]  dout,
    output logic                 frame_err
);
    tw_state_t state;
    logic [CNT_W-1:0] cnt;
    logic acc, first, last, beat_v;
    cplx_t prod;
    assign acc    = in_valid & in_ready;
    assign first  = state == IDLE && acc && in_sof;
    assign last   = cnt == CNT_W'(FRAME_N - 1);
    assign beat_v = first || (state == RUN && acc);
    // The ROM leaves reset in the same cycle the sof beat is presented, so its
    // registered word k lines up with beat k from then on.
    assign coeff_rst = rst || (state == IDLE ? !(in_valid && in_sof) : state == GAP);
    assign dout = prod;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: if (first) begin
                    state <= RUN;
                    cnt   <= CNT_W'(1);
                end
                RUN: if (!in_valid || last) begin
                    state     <= GAP;
                    cnt       <= '0;
                    in_ready  <= 1'b0;
                    frame_err <= !in_valid;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
    cmult_pipe u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (beat_v),
        .in_sof    (first),
        .in_eof    (state == RUN && acc && last),
        .din       (cplx_t'(din)),
        .coeff     (coeff_t'(coeff_in)),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .dout      (prod)
    );
endmodule

// File: tb/tb_twiddle_cmult_2_1.sv
// tb_twiddle_cmult_2_1: randomized self-checking bench with a frame-level reference model and a ROM stand-in
module tb_twiddle_cmult_2_1;
    import fft_pkg::*;
`ifdef TWIDDLE_ROUND_EN
    localparam longint RND = 2**(COEFF_FRAC-1);
    localparam logic [31:0] T4_EXP = {16'd1, 16'd0};
`else
    localparam longint RND = 0;
    localparam logic [31:0] T4_EXP = 32'd0;
`endif
    typedef struct { int due; logic sof; logic eof; logic [31:0] data; } exp_t;
    logic clk = 1'b0;
    logic rst, in_valid, in_sof, in_ready, coeff_rst, out_valid, out_sof, out_eof, frame_err;
    logic [31:0] din, dout, first_out;
    logic [21:0] coeff_in;
    logic [21:0] rom [FRAME_N];
    logic [4:0] ridx;
    exp_t q[$];
    bit m_in, m_gap;
    int m_beat, cyc, checks, failures;

    twiddle_cmult_2_1 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .din(din), .coeff_in(coeff_in), .coeff_rst(coeff_rst), .out_valid(out_valid),
        .out_sof(out_sof), .out_eof(out_eof), .dout(dout), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // coefficient ROM: registered output, reset holds index 0
    always @(posedge clk) begin
        if (coeff_rst) begin
            ridx     <= 5'd0;
            coeff_in <= rom[0];
        end else begin
            ridx     <= ridx + 5'd1;
            coeff_in <= rom[ridx + 5'd1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] clamp(input longint x);
        return x > 32767 ? 16'h7fff : x < -32768 ? 16'h8000 : 16'(x);
    endfunction

    function automatic logic [31:0] cmul(input logic [31:0] d, input logic [21:0] w);
        longint ar = longint'($signed(d[31:16]));
        longint ai = longint'($signed(d[15:0]));
        longint br = longint'($signed(w[21:11]));
        longint bi = longint'($signed(w[10:0]));
        longint re = (ar * br - ai * bi + RND) >>> COEFF_FRAC;
        longint im = (ar * bi + ai * br + RND) >>> COEFF_FRAC;
        return {clamp(re), clamp(im)};
    endfunction

    task automatic push(input int k);
        q.push_back('{due: cyc + 4, sof: k == 0, eof: k == FRAME_N - 1, data: cmul(din, rom[k])});
    endtask

    // one clock: predict acceptance from the current inputs, then check outputs after the edge
    task automatic tick();
        logic err_e = 1'b0;
        exp_t e;
        #1;
        if (rst) begin
            q.delete();
            m_in = 0;
            m_gap = 0;
            chk("coeff_rst_in_rst", coeff_rst, 1);
        end else begin
            chk("in_ready", in_ready, !m_gap);
            chk("coeff_rst", coeff_rst, m_gap || (!m_in && !(in_valid && in_sof)));
            if (m_gap) m_gap = 0;
            else if (!m_in) begin
                if (in_valid && in_sof) begin
                    push(0);
                    m_in = 1;
                    m_beat = 1;
                end
            end else if (!in_valid) begin
                m_in = 0;
                m_gap = 1;
                err_e = 1'b1;
            end else begin
                push(m_beat);
                if (m_beat == FRAME_N - 1) begin
                    m_in = 0;
                    m_gap = 1;
                end else m_beat++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("frame_err", frame_err, err_e);
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("out_valid", out_valid, 1);
            chk("dout", dout, e.data);
            chk("out_sof", out_sof, e.sof);
            chk("out_eof", out_eof, e.eof);
            if (e.sof) first_out = dout;
        end else chk("out_idle", {out_valid, out_sof, out_eof}, 0);
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        in_sof = 0;
        repeat (n) tick();
    endtask

    task automatic frame(input int len, input logic [31:0] d0, input bit fixed);
        for (int i = 0; i < len; i++) begin
            in_valid = 1;
            in_sof = i == 0 ? 1'b1 : 1'($urandom);
            din = fixed || i == 0 ? d0 : $urandom;
            tick();
        end
    endtask

    task automatic fill_rom(input logic [21:0] w);
        for (int k = 0; k < FRAME_N; k++) rom[k] = w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; in_sof = 0; din = 0; first_out = 0;
        for (int k = 0; k < FRAME_N; k++) rom[k] = 22'($urandom);
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_flags", {out_sof, out_eof, frame_err}, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_coeff_rst", coeff_rst, 1);
        rst = 0;
        idle(2);
        // unity twiddle
        fill_rom({11'd512, 11'd0});
        idle(1);
        frame(FRAME_N, {16'd1000, 16'd0}, 1);
        idle(6);
        chk("t1_first", first_out, {16'd1000, 16'd0});
        // multiply by j
        fill_rom({11'd0, 11'd512});
        idle(1);
        frame(FRAME_N, {16'd1000, 16'(-300)}, 0);
        idle(6);
        chk("t2_first", first_out, {16'd300, 16'd1000});
        // imaginary saturation
        rom[0] = {11'd1023, 11'd1023};
        idle(1);
        frame(FRAME_N, {16'd32767, 16'd32767}, 0);
        idle(6);
        chk("t3_first", first_out, {16'd0, 16'd32767});
        // rounding boundary
        rom[0] = {11'd256, 11'd0};
        idle(1);
        frame(FRAME_N, {16'd1, 16'd0}, 0);
        idle(6);
        chk("t4_first", first_out, T4_EXP);
        // back-to-back frames with in_valid held high
        for (int k = 0; k < FRAME_N; k++) rom[k] = 22'($urandom);
        idle(1);
        frame(FRAME_N, $urandom, 0);
        #1 chk("gap_ready", in_ready, 0);
        in_valid = 1;
        in_sof = 1;
        din = $urandom;
        tick();
        chk("gap_one_cycle", in_ready, 1);
        frame(FRAME_N, $urandom, 0);
        idle(6);
        // abort at beat 10, then realigned frame
        frame(10, $urandom, 0);
        idle(1);
        chk("abort_err", frame_err, 1);
        idle(5);
        frame(FRAME_N, $urandom, 0);
        idle(6);
        // reset mid-frame
        frame(12, $urandom, 0);
        rst = 1;
        tick();
        chk("rst_mid_valid", out_valid, 0);
        rst = 0;
        idle(4);
        // random traffic
        for (int k = 0; k < FRAME_N; k++) rom[k] = 22'($urandom);
        idle(1);
        for (int i = 0; i < 1500; i++) begin
            in_valid = $urandom_range(0, 39) != 0;
            in_sof = $urandom_range(0, 7) == 0;
            din = $urandom;
            rst = $urandom_range(0, 299) == 0;
            tick();
        end
        rst = 0;
        idle(6);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
